// File: rtl/calc_arbiter.sv
// Round-robin front end for one shared fixed-latency calc pipeline: grants one
// requester per cycle, issues its operands, and returns each result tagged with its ID.
module calc_arbiter #(
    parameter int N_REQ        = 4,
    parameter int CALC_LATENCY = 4,
    parameter int A_DWIDTH     = 16,
    parameter int B_DWIDTH     = 16,
    parameter int C_DWIDTH     = 16,
    parameter int D_DWIDTH     = 16,
    parameter int Q_DWIDTH     = 34,
    localparam int ID_W        = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             en_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ*A_DWIDTH-1:0]        req_a_i,
    input  logic [N_REQ*B_DWIDTH-1:0]        req_b_i,
    input  logic [N_REQ*C_DWIDTH-1:0]        req_c_i,
    input  logic [N_REQ*D_DWIDTH-1:0]        req_d_i,
    output logic                             calc_tvalid_o,
    output logic signed [A_DWIDTH-1:0]       calc_a_o,
    output logic signed [B_DWIDTH-1:0]       calc_b_o,
    output logic signed [C_DWIDTH-1:0]       calc_c_o,
    output logic signed [D_DWIDTH-1:0]       calc_d_o,
    input  logic                             calc_tvalid_i,
    input  logic signed [Q_DWIDTH-1:0]       calc_q_i,
    output logic                             rsp_valid_o,
    output logic [ID_W-1:0]                  rsp_id_o,
    output logic signed [Q_DWIDTH-1:0]       rsp_q_o,
    output logic                             busy_o,
    output logic                             err_o
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_id;
    logic            transfer;
    logic [ID_W-1:0] issue_id_p0;
    logic            tag_vld [CALC_LATENCY];
    logic [ID_W-1:0] tag_id  [CALC_LATENCY];
    logic            inflight;

    // Rotating search starting at ptr; reset and en_i both suppress the grant.
    always_comb begin
        transfer = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!transfer && req_valid_i[cand]) begin
                transfer = 1'b1;
                grant_id = cand;
            end
        end
        if (srst || !en_i) begin
            transfer = 1'b0;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (transfer) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // Stage p0: issue register feeding calc.
    always_ff @(posedge clk) begin
        if (srst) begin
            ptr           <= '0;
            calc_tvalid_o <= 1'b0;
            calc_a_o      <= '0;
            calc_b_o      <= '0;
            calc_c_o      <= '0;
            calc_d_o      <= '0;
            issue_id_p0   <= '0;
        end else begin
            calc_tvalid_o <= transfer;
            if (transfer) begin
                calc_a_o    <= req_a_i[int'(grant_id)*A_DWIDTH +: A_DWIDTH];
                calc_b_o    <= req_b_i[int'(grant_id)*B_DWIDTH +: B_DWIDTH];
                calc_c_o    <= req_c_i[int'(grant_id)*C_DWIDTH +: C_DWIDTH];
                calc_d_o    <= req_d_i[int'(grant_id)*D_DWIDTH +: D_DWIDTH];
                issue_id_p0 <= grant_id;
                ptr         <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    // Tag pipe: stage 0 captures the issue tag on the edge calc samples its operands,
    // so the last stage lines up with calc_tvalid_i.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < CALC_LATENCY; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
            end
        end else begin
            tag_vld[0] <= calc_tvalid_o;
            tag_id[0]  <= issue_id_p0;
            for (int k = 1; k < CALC_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // busy_o reflects what will be held in the issue, tag and response registers after this edge.
    always_comb begin
        inflight = transfer | calc_tvalid_o | calc_tvalid_i;
        for (int k = 0; k < CALC_LATENCY - 1; k++) begin
            inflight = inflight | tag_vld[k];
        end
    end

    // Response stage: result paired with the tag leaving the pipe.
    always_ff @(posedge clk) begin
        if (srst) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_q_o     <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= calc_tvalid_i;
            busy_o      <= inflight;
            if (calc_tvalid_i) begin
                rsp_q_o  <= calc_q_i;
                rsp_id_o <= tag_id[CALC_LATENCY-1];
            end
            if (calc_tvalid_i != tag_vld[CALC_LATENCY-1]) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Testbench for calc_arbiter: a latency-4 calc stub (q = a*c + b - d) plus a
// transaction-level model of round-robin grants and in-order tagged responses.
module tb_calc_arbiter;

    localparam int N   = 4;
    localparam int L   = 4;
    localparam int AW  = 16;
    localparam int BW  = 16;
    localparam int CW  = 16;
    localparam int DW  = 16;
    localparam int QW  = 34;
    localparam int IDW = 2;
    localparam int N_RAND = 300;

    logic clk = 1'b0;
    logic srst, en, inject;
    logic [N-1:0] valid, ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N*CW-1:0] req_c;
    logic [N*DW-1:0] req_d;
    logic signed [AW-1:0] op_a [N];
    logic signed [BW-1:0] op_b [N];
    logic signed [CW-1:0] op_c [N];
    logic signed [DW-1:0] op_d [N];
    logic calc_tv_o, calc_tv_i;
    logic signed [AW-1:0] ca;
    logic signed [BW-1:0] cb;
    logic signed [CW-1:0] cc;
    logic signed [DW-1:0] cd;
    logic signed [QW-1:0] calc_q;
    logic rsp_v, busy, err;
    logic [IDW-1:0] rsp_id;
    logic signed [QW-1:0] rsp_q;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ptr_m = 0;

    typedef struct {
        int     id;
        longint q;
        int     due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    calc_arbiter #(
        .N_REQ(N), .CALC_LATENCY(L), .A_DWIDTH(AW), .B_DWIDTH(BW),
        .C_DWIDTH(CW), .D_DWIDTH(DW), .Q_DWIDTH(QW)
    ) dut (
        .clk(clk), .srst(srst), .en_i(en),
        .req_valid_i(valid), .req_ready_o(ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_d_i(req_d),
        .calc_tvalid_o(calc_tv_o), .calc_a_o(ca), .calc_b_o(cb), .calc_c_o(cc), .calc_d_o(cd),
        .calc_tvalid_i(calc_tv_i), .calc_q_i(calc_q),
        .rsp_valid_o(rsp_v), .rsp_id_o(rsp_id), .rsp_q_o(rsp_q),
        .busy_o(busy), .err_o(err)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_c = '0;
        req_d = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = op_a[i];
            req_b[i*BW +: BW] = op_b[i];
            req_c[i*CW +: CW] = op_c[i];
            req_d[i*DW +: DW] = op_d[i];
        end
    end

    // calc stub: fixed latency L from the tvalid sample edge, cleared by srst.
    logic stub_v [L];
    logic signed [QW-1:0] stub_q [L];
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < L; k++) stub_v[k] <= 1'b0;
        end else begin
            stub_v[0] <= calc_tv_o;
            stub_q[0] <= QW'(longint'(ca) * longint'(cc) + longint'(cb) - longint'(cd));
            for (int k = 1; k < L; k++) begin
                stub_v[k] <= stub_v[k-1];
                stub_q[k] <= stub_q[k-1];
            end
        end
    end
    assign calc_tv_i = stub_v[L-1] | inject;
    assign calc_q    = stub_q[L-1];

    function automatic longint calc_ref(longint a, longint b, longint c, longint d);
        return a * c + b - d;
    endfunction

    // First valid requester at or after p (wrapping); -1 if none or disabled.
    function automatic int model_grant(int p, logic [N-1:0] v, logic e);
        int j;
        if (!e) return -1;
        for (int off = 0; off < N; off++) begin
            j = (p + off) % N;
            if (v[j[IDW-1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic randomize_op(int i);
        op_a[i] = AW'($urandom);
        op_b[i] = BW'($urandom);
        op_c[i] = CW'($urandom);
        op_d[i] = DW'($urandom);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        valid = '0;
        en = 1'b1;
        inject = 1'b0;
        advance();
        advance();
        srst = 1'b0;
        ptr_m = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        valid = '1;
        en = 1'b1;
        for (int i = 0; i < N; i++) randomize_op(i);
        advance();
        advance();
        @(negedge clk);
        checks++; if (ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (calc_tv_o !== 1'b0) begin errors++; $display("FAIL reset_calc_tvalid: got %b want 0", calc_tv_o); end
        checks++; if (ca !== '0 || cb !== '0 || cc !== '0 || cd !== '0) begin errors++; $display("FAIL reset_operands: got %0d %0d %0d %0d want 0", ca, cb, cc, cd); end
        checks++; if (rsp_v !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_v); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_q !== '0) begin errors++; $display("FAIL reset_rsp_q: got %0d want 0", rsp_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        valid = '0;
        srst = 1'b0;
        ptr_m = 0;
        advance();
    endtask

    task automatic test_single();
        op_a[2] = 16'sd10; op_b[2] = 16'sd3; op_c[2] = 16'sd2; op_d[2] = 16'sd1;
        valid = 4'b0100;
        @(negedge clk);
        checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", ready); end
        advance();
        valid = '0;
        @(negedge clk);
        checks++; if (calc_tv_o !== 1'b1) begin errors++; $display("FAIL single_issue: got %b want 1", calc_tv_o); end
        checks++; if (ca !== 16'sd10 || cb !== 16'sd3 || cc !== 16'sd2 || cd !== 16'sd1) begin
            errors++; $display("FAIL single_operands: got %0d %0d %0d %0d want 10 3 2 1", ca, cb, cc, cd); end
        for (int k = 2; k <= 8; k++) begin
            advance();
            @(negedge clk);
            if (k == 2) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
            end
            if (k < 6 || k > 6) begin
                checks++; if (rsp_v !== 1'b0) begin errors++; $display("FAIL single_rsp_early_late t%0d: got %b want 0", k, rsp_v); end
            end else begin
                checks++; if (rsp_v !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_v); end
                checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
                checks++; if (rsp_q !== 34'sd22) begin errors++; $display("FAIL single_rsp_q: got %0d want 22", rsp_q); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        advance();
    endtask

    task automatic test_contention();
        int g;
        logic [N-1:0] exp_r;
        do_reset();
        for (int i = 0; i < N; i++) randomize_op(i);
        valid = '1;
        for (int k = 0; k < 22; k++) begin
            if (k == 8) valid = '0;
            @(negedge clk);
            if (k < 8) begin
                g = k % N;
                exp_r = N'(1) << g;
                checks++; if (ready !== exp_r) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", k, ready, exp_r); end
                sb.push_back('{id: g, q: calc_ref(op_a[g], op_b[g], op_c[g], op_d[g]), due: cyc + 6});
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                checks++; if (rsp_v !== 1'b1) begin errors++; $display("FAIL contention_rsp_valid: got %b want 1", rsp_v); end
                checks++; if (rsp_id !== IDW'(sb[0].id)) begin errors++; $display("FAIL contention_rsp_id: got %0d want %0d", rsp_id, sb[0].id); end
                checks++; if (rsp_q !== QW'(sb[0].q)) begin errors++; $display("FAIL contention_rsp_q: got %0d want %0d", rsp_q, sb[0].q); end
                void'(sb.pop_front());
            end else begin
                checks++; if (rsp_v !== 1'b0) begin errors++; $display("FAIL contention_rsp_spurious: got %b want 0", rsp_v); end
            end
            advance();
            if (k < 8) randomize_op(k % N);
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL contention_missing: got %0d outstanding want 0", sb.size()); end
    endtask

    task automatic test_pointer_skip();
        do_reset();
        valid = 4'b0010;
        @(negedge clk);
        checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL skip_first: got %b want 0010", ready); end
        advance();
        valid = 4'b1001;
        @(negedge clk);
        checks++; if (ready !== 4'b1000) begin errors++; $display("FAIL skip_to3: got %b want 1000", ready); end
        advance();
        @(negedge clk);
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL skip_to0: got %b want 0001", ready); end
        advance();
        valid = '0;
        for (int k = 0; k < 8; k++) advance();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL skip_err: got %b want 0", err); end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0;
        valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (ready !== '0) begin errors++; $display("FAIL enable_ready%0d: got %b want 0", k, ready); end
            checks++; if (calc_tv_o !== 1'b0) begin errors++; $display("FAIL enable_issue%0d: got %b want 0", k, calc_tv_o); end
            advance();
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL enable_grant: got %b want 0001", ready); end
        advance();
        valid = '0;
        @(negedge clk);
        checks++; if (calc_tv_o !== 1'b1) begin errors++; $display("FAIL enable_issue: got %b want 1", calc_tv_o); end
        for (int k = 0; k < 8; k++) advance();
    endtask

    task automatic test_midflight_reset();
        do_reset();
        valid = '1;
        for (int k = 0; k < 3; k++) advance();
        srst = 1'b1;
        @(negedge clk);
        checks++; if (ready !== '0) begin errors++; $display("FAIL midrst_ready_in_reset: got %b want 0", ready); end
        advance();
        srst = 1'b0;
        valid = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
            end
            checks++; if (rsp_v !== 1'b0) begin errors++; $display("FAIL midrst_rsp%0d: got %b want 0", k, rsp_v); end
            advance();
        end
        valid = '1;
        @(negedge clk);
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr: got %b want 0001", ready); end
        advance();
        valid = '0;
        for (int k = 0; k < 8; k++) advance();
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err); end
    endtask

    task automatic test_error();
        do_reset();
        advance();
        inject = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL error_before: got %b want 0", err); end
        advance();
        inject = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_set: got %b want 1", err); end
        checks++; if (rsp_v !== 1'b1) begin errors++; $display("FAIL error_rsp_emitted: got %b want 1", rsp_v); end
        for (int k = 0; k < 4; k++) begin
            advance();
            @(negedge clk);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_sticky%0d: got %b want 1", k, err); end
        end
        srst = 1'b1;
        advance();
        srst = 1'b0;
        ptr_m = 0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL error_cleared: got %b want 0", err); end
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] exp_r;
        int g;
        do_reset();
        pend = '0;
        for (int k = 0; k < N_RAND + 14; k++) begin
            if (k < N_RAND) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        randomize_op(i);
                    end
                end
                valid = pend;
                en = ($urandom_range(0, 7) != 0);
            end else begin
                valid = '0;
            end
            @(negedge clk);
            g = model_grant(ptr_m, valid, en);
            exp_r = (g >= 0) ? (N'(1) << g) : '0;
            checks++; if (ready !== exp_r) begin errors++; $display("FAIL random_grant c%0d: got %b want %b", cyc, ready, exp_r); end
            if (g >= 0) begin
                sb.push_back('{id: g, q: calc_ref(op_a[g], op_b[g], op_c[g], op_d[g]), due: cyc + 6});
                ptr_m = (g + 1) % N;
                pend[g] = 1'b0;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                checks++; if (rsp_v !== 1'b1) begin errors++; $display("FAIL random_rsp_valid c%0d: got %b want 1", cyc, rsp_v); end
                checks++; if (rsp_id !== IDW'(sb[0].id)) begin errors++; $display("FAIL random_rsp_id c%0d: got %0d want %0d", cyc, rsp_id, sb[0].id); end
                checks++; if (rsp_q !== QW'(sb[0].q)) begin errors++; $display("FAIL random_rsp_q c%0d: got %0d want %0d", cyc, rsp_q, sb[0].q); end
                void'(sb.pop_front());
            end else begin
                checks++; if (rsp_v !== 1'b0) begin errors++; $display("FAIL random_rsp_spurious c%0d: got %b want 0", cyc, rsp_v); end
            end
            advance();
        end
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL random_missing: got %0d outstanding want 0", sb.size()); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL random_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_busy: got %b want 0", busy); end
    endtask

    initial begin
        srst = 1'b1;
        en = 1'b1;
        inject = 1'b0;
        valid = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; op_d[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_pointer_skip();
        test_enable();
        test_midflight_reset();
        test_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Round-robin scheduler that shares one fixed-latency, non-stallable `calc` pipeline between `N_REQ` independent requesters. It accepts one operand set per cycle through per-requester valid/ready handshakes and issues it into `calc`. It tracks the issuing requester ID through a tag pipeline matched to `CALC_LATENCY`, then returns each result tagged with that ID. It sits between the requester front-ends and the single `calc` instance.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `CALC_LATENCY`, default 4: `calc` latency, from its `tvalid_i` sample edge to `tvalid_o`.
- `A_DWIDTH`, `B_DWIDTH`, `C_DWIDTH`, `D_DWIDTH`, `Q_DWIDTH`, defaults from `calc_pkg`: operand and result widths.
- `ID_W`, localparam = max(1, $clog2(N_REQ)).
- Reset is `srst`: synchronous, active-high. Clock is `clk`.
- `clk` in 1: clock.
- `srst` in 1: synchronous active-high reset.
- `en_i` in 1: arbitration enable; when low, no grants are made.
- `req_valid_i` in N_REQ: request valid, one bit per requester.
- `req_ready_o` out N_REQ: grant, one-hot or zero.
- `req_a_i` in N_REQ*A_DWIDTH: packed operand a; requester i occupies slice [i*A_DWIDTH +: A_DWIDTH]. Same packing applies to b, c and d.
- `req_b_i` in N_REQ*B_DWIDTH: packed operand b.
- `req_c_i` in N_REQ*C_DWIDTH: packed operand c.
- `req_d_i` in N_REQ*D_DWIDTH: packed operand d.
- `calc_tvalid_o` out 1: issue strobe to `calc`.
- `calc_a_o`, `calc_b_o`, `calc_c_o`, `calc_d_o` out A/B/C/D_DWIDTH: signed operands to `calc`.
- `calc_tvalid_i` in 1: result strobe from `calc`.
- `calc_q_i` in Q_DWIDTH: signed result from `calc`.
- `rsp_valid_o` out 1: response strobe. There is no backpressure; the consumer must accept it every cycle.
- `rsp_id_o` out ID_W: requester index that the response belongs to.
- `rsp_q_o` out Q_DWIDTH: result value.
- `busy_o` out 1: at least one operation is in flight (issue register, tag pipe or response register).
- `err_o` out 1: sticky tag/result mismatch flag.

## Operation
- **Arbitration (combinational):**
  - Priority pointer `ptr` (ID_W bits) defines the search order `ptr`, `ptr+1`, … modulo N_REQ.
  - The first i in that order with `req_valid_i[i]` is granted: `req_ready_o[i]`=1, all other ready bits 0.
  - No grant when `en_i`=0 or when no request is valid.
  - `req_ready_o` depends on `req_valid_i`; requesters must not make valid depend on ready.
- **Transfer:** occurs when `req_valid_i[i]` & `req_ready_o[i]`.
  - At most one transfer per cycle; sustained throughput is 1/cycle.
  - After a transfer from requester i, `ptr` <= (i+1) mod N_REQ; otherwise `ptr` holds.
- **Issue register:** on a transfer, register the granted operands and `calc_tvalid_o`=1 for exactly one cycle, and push {valid=1, id=i} into the tag pipe. Without a transfer, `calc_tvalid_o`=0 and operands hold their previous values.
- **Tag pipe:** CALC_LATENCY stages of {valid, id}, shifting every cycle.
  - Stage 0 loads the issue-register tag in the same cycle that `calc_tvalid_o` is high.
  - The last stage aligns with `calc_tvalid_i`.
- **Response register:** each cycle, `rsp_valid_o` <= `calc_tvalid_i`; on `calc_tvalid_i`, load `rsp_q_o` <= `calc_q_i` and `rsp_id_o` <= tag id.
- **Error detection:**
  - If `calc_tvalid_i` differs from the tag's last-stage valid, `err_o` <= 1.
  - `err_o` stays set until `srst`.
  - On mismatch with `calc_tvalid_i`=1, the response is still emitted using the stale tag id.
- **Reset:** `calc` shares `srst`.
  - All outputs reset to 0: `req_ready_o`, `calc_tvalid_o`, `calc_*_o` operands, `rsp_valid_o`, `rsp_id_o`, `rsp_q_o`, `busy_o`, `err_o`.
  - Reset also clears `ptr`=0 and the tag pipe.
  - Reset mid-operation discards all in-flight operations; no response is produced for any of them.
  - Requests presented during `srst` are not granted.

## Timing
- Transfer in cycle T → `calc_tvalid_o`=1 in cycle T+1 → `calc_tvalid_i` in cycle T+1+CALC_LATENCY → `rsp_valid_o` in cycle T+2+CALC_LATENCY (T+6 with defaults).
- Responses are returned in issue order; back-to-back transfers give back-to-back responses.
- `en_i` deassertion blocks new grants in the same cycle; in-flight operations still complete.
- `busy_o` is registered: the OR of the issue valid, all tag-stage valids and `rsp_valid_o`, as of the next edge.
- Only the granted requester is ever accepted, so simultaneous valids are never lost; losers keep valid asserted and hold their data.

## Test plan
- **Single request:** reset, then requester 2 presents a=10, b=3, c=2, d=1 for one cycle at T. Expect `req_ready_o`=4'b0100 at T; `calc_tvalid_o` at T+1 with those operands; `rsp_valid_o` at T+6 with `rsp_id_o`=2 and `rsp_q_o` = the `calc` result (22); `err_o`=0.
- **Full contention:** all 4 valid continuously for 8 cycles. Expect grants 0,1,2,3,0,1,2,3 on consecutive cycles, 8 responses on consecutive cycles with ids 0,1,2,3,0,1,2,3, and each q matching its own operands.
- **Pointer skip:** after a grant to 1, only requesters 0 and 3 are valid. Expect grant 3, then 0.
- **Enable gating:** requester 0 valid and `en_i`=0 for 5 cycles. Expect no ready and no `calc_tvalid_o`. Raise `en_i`: expect a grant in the same cycle.
- **Mid-flight reset:** issue 3 ops, assert `srst` for 1 cycle at T+2. Expect no `rsp_valid_o` afterwards, `busy_o`=0 after reset, and `ptr`=0 (requester 0 wins next contention).
- **Error injection:** drive `calc_tvalid_i`=1 from a stub with the tag pipe empty. Expect `err_o`=1 next cycle and held there until `srst`.
